// File: rtl/karatsuba_pkg.sv
// Shared types and sizes for the Karatsuba multiply-accumulate controller.
package karatsuba_pkg;

  localparam int WIDTH     = 32;
  localparam int HALF      = WIDTH / 2;
  localparam int PROD_W    = 2 * (HALF + 1);
  localparam int ACC_WIDTH = 2 * WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    MUL_HI,
    MUL_LO,
    MUL_MID,
    COMBINE,
    DONE
  } state_t;

endpackage

// File: rtl/karatsuba_mul17.sv
// Combinational unsigned multiplier shared by all three Karatsuba partial products.
module karatsuba_mul17 #(
  parameter int IN_W = karatsuba_pkg::HALF + 1
) (
  input  logic [IN_W-1:0]   i_a,
  input  logic [IN_W-1:0]   i_b,
  output logic [2*IN_W-1:0] o_p
);

  assign o_p = {{IN_W{1'b0}}, i_a} * {{IN_W{1'b0}}, i_b};

endmodule

// File: rtl/karatsuba_mac_ctrl.sv
// Sequential Karatsuba MAC: one shared 17x17 multiplier, three partial products,
// then load/accumulate into a 64-bit accumulator with a sticky carry-out flag.
module karatsuba_mac_ctrl #(
  parameter int WIDTH     = karatsuba_pkg::WIDTH,
  parameter int ACC_WIDTH = karatsuba_pkg::ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 acc_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 ovf,
  output logic                 busy
);

  import karatsuba_pkg::*;

  localparam int L_HALF = WIDTH / 2;
  localparam int MUL_W  = L_HALF + 1;
  localparam int PP_W   = 2 * MUL_W;

  state_t r_state, w_state_next;

  logic [L_HALF-1:0]    r_a1, r_a0, r_b1, r_b0;
  logic                 r_acc_en;
  logic [PP_W-1:0]      r_p1, r_p2, r_p3;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_ovf;
  logic                 r_out_valid;

  logic                 w_accept;
  logic [MUL_W-1:0]     w_mul_a, w_mul_b;
  logic [PP_W-1:0]      w_mul_p;
  logic [ACC_WIDTH-1:0] w_mid;
  logic [ACC_WIDTH-1:0] w_prod;
  logic [ACC_WIDTH:0]   w_sum;

  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_acc;
  assign ovf       = r_ovf;

  // The middle term p3 - p1 - p2 is never negative, so plain wide subtraction is exact.
  assign w_mid  = ACC_WIDTH'(r_p3) - ACC_WIDTH'(r_p1) - ACC_WIDTH'(r_p2);
  assign w_prod = (ACC_WIDTH'(r_p1) << WIDTH) + (w_mid << L_HALF) + ACC_WIDTH'(r_p2);
  assign w_sum  = {1'b0, r_acc} + {1'b0, w_prod};

  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      MUL_HI: begin
        w_mul_a = {1'b0, r_a1};
        w_mul_b = {1'b0, r_b1};
      end
      MUL_LO: begin
        w_mul_a = {1'b0, r_a0};
        w_mul_b = {1'b0, r_b0};
      end
      MUL_MID: begin
        w_mul_a = {1'b0, r_a1} + {1'b0, r_a0};
        w_mul_b = {1'b0, r_b1} + {1'b0, r_b0};
      end
      default: ;
    endcase
  end

  karatsuba_mul17 #(.IN_W(MUL_W)) u_mul (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_mul_p)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = MUL_HI;
      MUL_HI:  w_state_next = MUL_LO;
      MUL_LO:  w_state_next = MUL_MID;
      MUL_MID: w_state_next = COMBINE;
      COMBINE: w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = w_accept ? MUL_HI : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a1        <= '0;
      r_a0        <= '0;
      r_b1        <= '0;
      r_b0        <= '0;
      r_acc_en    <= 1'b0;
      r_p1        <= '0;
      r_p2        <= '0;
      r_p3        <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // A new operation starts from clean partial products.
      if (w_accept) begin
        r_a1     <= a[WIDTH-1:L_HALF];
        r_a0     <= a[L_HALF-1:0];
        r_b1     <= b[WIDTH-1:L_HALF];
        r_b0     <= b[L_HALF-1:0];
        r_acc_en <= acc_en;
        r_p1     <= '0;
        r_p2     <= '0;
        r_p3     <= '0;
      end
      case (r_state)
        MUL_HI:  r_p1 <= w_mul_p;
        MUL_LO:  r_p2 <= w_mul_p;
        MUL_MID: r_p3 <= w_mul_p;
        COMBINE: begin
          if (r_acc_en) begin
            r_acc <= w_sum[ACC_WIDTH-1:0];
            r_ovf <= r_ovf | w_sum[ACC_WIDTH];
          end else begin
            r_acc <= w_prod;
            r_ovf <= 1'b0;
          end
          r_out_valid <= 1'b1;
        end
        DONE:    if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
